dcache_store: RTL and testbench
===============================

# dcache_store

Direct-mapped, write-back data cache array that sits directly downstream of the processor controller. It answers hit/dirty queries for the current ALU address and applies the controller's `we_cache` writes. It also sequences the word-by-word victim writeback and refill bursts to data memory. Blocks are 4 words; the controller decides when to stall, writeback and refill, and this block only stores data and streams bursts.

## Interface
- `INDEX_BITS`, default 6: number of lines = 2^INDEX_BITS. Tag width = 28 − INDEX_BITS.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `addr`  in  32  byte address (ALU result). Word offset = addr[3:2]; index = addr[INDEX_BITS+3:4]; tag = addr[31:INDEX_BITS+4].
- `cache_hit`  out  1  indexed line valid and tag match; forced 0 while `busy`.
- `cache_dirty`  out  1  indexed line valid and dirty (victim dirty), regardless of tag.
- `read_data`  out  32  word at index/offset of `addr`.
- `we_cache`  in  1  write strobe from controller.
- `cache_input_type`  in  1  0 = metadata update, 1 = store from ALU path.
- `set_valid`, `set_dirty`  in  1 each  metadata values applied by `we_cache`.
- `store_data`  in  32  store word.
- `store_miss`  out  1  one-cycle pulse when a store is dropped on a miss.
- `wb_start`, `refill_start`  in  1 each  burst requests, sampled only in IDLE.
- `wb_valid`  out  1  writeback word presented.
- `wb_addr`  out  32  address of the presented word, {victim tag, index, cnt, 2'b00}.
- `wb_data`  out  32  data of the presented word.
- `mem_wready`  in  1  memory accepts `wb_data`.
- `mem_rvalid`  in  1  refill word valid.
- `mem_rdata`  in  32  refill word.
- `wb_done`, `refill_done`  out  1 each  one-cycle completion pulses.
- `busy`  out  1  state ≠ IDLE.

## Operation
- Per-line storage: tag, valid, dirty, and 4×32 data.
- FSM states: IDLE, WRITEBACK, REFILL. A 2-bit word counter `cnt` runs during bursts.
- IDLE, `wb_start`=1:
  - Latch index and victim tag, set `cnt`=0, go to WRITEBACK.
  - If the victim is not dirty, the request is still accepted and the burst runs.
- IDLE, `refill_start`=1 with `wb_start`=0:
  - Latch index and request tag, set `cnt`=0, go to REFILL.
- Both starts in the same cycle: writeback wins and `refill_start` is dropped.
- Any accepted start: a simultaneous `we_cache` is ignored.
- IDLE, `we_cache`, `cache_input_type`=1:
  - Hit: write `store_data` to the word; dirty ← `set_dirty`.
  - Miss: no state change; `store_miss` pulses the next cycle.
- IDLE, `we_cache`, `cache_input_type`=0: tag ← addr tag, valid ← `set_valid`, dirty ← `set_dirty`; data unchanged.
- WRITEBACK:
  - `wb_valid`=1; `wb_data` = latched line word `cnt`.
  - Each edge with `mem_wready`=1 advances `cnt`.
  - On acceptance of word 3: dirty ← 0, go to IDLE, pulse `wb_done`.
- REFILL:
  - Each edge with `mem_rvalid`=1 writes `mem_rdata` to word `cnt` of the latched index and increments `cnt`.
  - On word 3: tag ← latched tag, valid ← 1, dirty ← 0, go to IDLE, pulse `refill_done`.
- While `busy`, `we_cache` and both starts are ignored.
- Reset (asserted):
  - State IDLE, `cnt`=0, all valid and dirty bits 0.
  - All outputs 0 except `read_data`/`wb_data`, which are don't-care; data array is not reset.
  - Reset mid-burst aborts the burst, and no done pulse is produced.

## Timing
- `cache_hit`, `cache_dirty`, `read_data`: combinational from `addr` in the same cycle.
- A store or metadata write is visible on the cycle after its edge.
- `wb_valid`/`wb_addr`/`wb_data` are registered and first valid in the cycle after `wb_start`. They hold stable while `mem_wready`=0.
- `wb_done`/`refill_done` are high in the first IDLE cycle after the final word edge.
- Minimum latency from start to done is 5 cycles, with stalls adding 1 cycle each.
- `store_miss` is high in the cycle after the dropped `we_cache`.

## Test plan
- Reset, then `addr`=0x40 → `cache_hit`=0, `cache_dirty`=0, `busy`=0.
- `refill_start` @ 0x40, then `mem_rdata` A0..A3 with `mem_rvalid` gaps of 1 cycle:
  - Expect `refill_done` 8 cycles after start.
  - `addr`=0x48 → `read_data`=A2, hit=1, dirty=0.
- Store hit: `we_cache`, type=1, `set_dirty`=1, 0xDEADBEEF @ 0x44 → next cycle `read_data`=0xDEADBEEF, dirty=1.
- Conflicting address 0x444 → hit=0, dirty=1. Then `wb_start` with `mem_wready` low for 2 cycles:
  - Expect `wb_addr` 0x40, 0x44, 0x48, 0x4C and `wb_data` A0, 0xDEADBEEF, A2, A3.
  - Expect `wb_done`, then dirty=0.
- `wb_start` and `refill_start` together, with `we_cache` during busy → only the writeback runs; the store is ignored.
- Store @ 0x444 on miss → `store_miss` pulse, line unchanged.
- Assert `rst_n` low after 2 refill words → `busy`=0 immediately, no `refill_done`, hit=0 @ 0x40.

Source files
------------

// File: rtl/dcache_store_if.sv
// Controller/memory-facing signal bundle of the direct-mapped data cache.
// The cache side uses the slave modport; the controller/memory side uses master.
interface dcache_store_if;
  logic [31:0] addr;
  logic        cache_hit;
  logic        cache_dirty;
  logic [31:0] read_data;
  logic        we_cache;
  logic        cache_input_type;
  logic        set_valid;
  logic        set_dirty;
  logic [31:0] store_data;
  logic        store_miss;
  logic        wb_start;
  logic        refill_start;
  logic        wb_valid;
  logic [31:0] wb_addr;
  logic [31:0] wb_data;
  logic        mem_wready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        wb_done;
  logic        refill_done;
  logic        busy;

  modport slave (
    input  addr, we_cache, cache_input_type, set_valid, set_dirty, store_data,
           wb_start, refill_start, mem_wready, mem_rvalid, mem_rdata,
    output cache_hit, cache_dirty, read_data, store_miss, wb_valid, wb_addr,
           wb_data, wb_done, refill_done, busy
  );

  modport master (
    output addr, we_cache, cache_input_type, set_valid, set_dirty, store_data,
           wb_start, refill_start, mem_wready, mem_rvalid, mem_rdata,
    input  cache_hit, cache_dirty, read_data, store_miss, wb_valid, wb_addr,
           wb_data, wb_done, refill_done, busy
  );
endinterface

// File: rtl/dcache_store.sv
// Direct-mapped write-back cache array with 4-word lines: hit/dirty lookup,
// controller writes, and word-serial victim writeback / refill bursts.
module dcache_store #(
  parameter int INDEX_BITS = 6
) (
  input logic           clk,
  input logic           rst_n,
  dcache_store_if.slave bus
);
  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 28 - INDEX_BITS;

  typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} state_t;

  state_t                state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [INDEX_BITS-1:0] idx_q, idx_d;
  logic [TAG_W-1:0]      ltag_q, ltag_d;
  logic                  store_miss_q, store_miss_d;
  logic                  wb_done_q, refill_done_q;

  logic [TAG_W-1:0]      tag_q  [LINES];
  logic [LINES-1:0]      valid_q, dirty_q;
  logic [31:0]           data_q [LINES][4];

  logic [1:0]            a_off;
  logic [INDEX_BITS-1:0] a_idx;
  logic [TAG_W-1:0]      a_tag;
  logic                  line_match;
  logic                  store_we, meta_we, wb_last, refill_we, refill_last;
  logic                  unused_addr_bits;

  assign a_off            = bus.addr[3:2];
  assign a_idx            = bus.addr[INDEX_BITS+3:4];
  assign a_tag            = bus.addr[31:INDEX_BITS+4];
  assign unused_addr_bits = ^bus.addr[1:0];
  assign line_match       = valid_q[a_idx] && (tag_q[a_idx] == a_tag);

  assign bus.cache_hit   = line_match && (state_q == IDLE);
  assign bus.cache_dirty = valid_q[a_idx] && dirty_q[a_idx];
  assign bus.read_data   = data_q[a_idx][a_off];
  assign bus.store_miss  = store_miss_q;
  assign bus.wb_valid    = (state_q == WRITEBACK);
  assign bus.wb_addr     = {ltag_q, idx_q, cnt_q, 2'b00};
  assign bus.wb_data     = data_q[idx_q][cnt_q];
  assign bus.wb_done     = wb_done_q;
  assign bus.refill_done = refill_done_q;
  assign bus.busy        = (state_q != IDLE);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    ltag_d       = ltag_q;
    store_miss_d = 1'b0;
    store_we     = 1'b0;
    meta_we      = 1'b0;
    wb_last      = 1'b0;
    refill_we    = 1'b0;
    refill_last  = 1'b0;
    case (state_q)
      IDLE: begin
        // An accepted burst start takes priority over any same-cycle write.
        if (bus.wb_start) begin
          state_d = WRITEBACK;
          cnt_d   = 2'd0;
          idx_d   = a_idx;
          ltag_d  = tag_q[a_idx];
        end else if (bus.refill_start) begin
          state_d = REFILL;
          cnt_d   = 2'd0;
          idx_d   = a_idx;
          ltag_d  = a_tag;
        end else if (bus.we_cache) begin
          if (bus.cache_input_type) begin
            store_we     = line_match;
            store_miss_d = !line_match;
          end else begin
            meta_we = 1'b1;
          end
        end
      end
      WRITEBACK: begin
        if (bus.mem_wready) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            wb_last = 1'b1;
            state_d = IDLE;
          end
        end
      end
      REFILL: begin
        if (bus.mem_rvalid) begin
          refill_we = 1'b1;
          cnt_d     = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            refill_last = 1'b1;
            state_d     = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= 2'd0;
      idx_q         <= '0;
      ltag_q        <= '0;
      store_miss_q  <= 1'b0;
      wb_done_q     <= 1'b0;
      refill_done_q <= 1'b0;
      valid_q       <= '0;
      dirty_q       <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      ltag_q        <= ltag_d;
      store_miss_q  <= store_miss_d;
      wb_done_q     <= wb_last;
      refill_done_q <= refill_last;
      if (store_we) dirty_q[a_idx] <= bus.set_dirty;
      if (meta_we) begin
        valid_q[a_idx] <= bus.set_valid;
        dirty_q[a_idx] <= bus.set_dirty;
      end
      if (wb_last) dirty_q[idx_q] <= 1'b0;
      if (refill_last) begin
        valid_q[idx_q] <= 1'b1;
        dirty_q[idx_q] <= 1'b0;
      end
    end
  end

  // Tags and data are meaningless until valid is set, so they carry no reset.
  always_ff @(posedge clk) begin
    if (meta_we)     tag_q[a_idx] <= a_tag;
    if (refill_last) tag_q[idx_q] <= ltag_q;
    if (store_we)    data_q[a_idx][a_off] <= bus.store_data;
    if (refill_we)   data_q[idx_q][cnt_q] <= bus.mem_rdata;
  end
endmodule

// File: tb/tb_dcache_store.sv
// Directed bench for dcache_store: refill, store hit/miss, metadata write,
// writeback with stalls, start arbitration and reset during a burst.
module tb_dcache_store;
  logic clk = 1'b0;
  logic rst_n;
  int   n_assert = 0;
  int   n_fail   = 0;

  logic [31:0] A  [4] = '{32'hA000_0000, 32'hA000_0001, 32'hA000_0002, 32'hA000_0003};
  logic [31:0] WB [4] = '{32'hA000_0000, 32'hDEAD_BEEF, 32'hA000_0002, 32'hA000_0003};

  dcache_store_if bus ();

  dcache_store #(.INDEX_BITS(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.addr = 32'h40;
    step();
    step();
    n_assert++; if (bus.cache_hit !== 1'b0) begin n_fail++; $display("FAIL reset_hit: got %b exp 0", bus.cache_hit); end
    n_assert++; if (bus.cache_dirty !== 1'b0) begin n_fail++; $display("FAIL reset_dirty: got %b exp 0", bus.cache_dirty); end
    n_assert++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b exp 0", bus.busy); end
    n_assert++; if ({bus.wb_valid, bus.wb_done, bus.refill_done, bus.store_miss} !== 4'b0) begin
      n_fail++; $display("FAIL reset_pulses: got %b exp 0000", {bus.wb_valid, bus.wb_done, bus.refill_done, bus.store_miss}); end
    n_assert++; if (bus.wb_addr !== 32'h0) begin n_fail++; $display("FAIL reset_wb_addr: got %h exp 0", bus.wb_addr); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_refill();
    bus.addr = 32'h40;
    bus.refill_start = 1'b1;
    step();
    bus.refill_start = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      n_assert++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL refill_busy c%0d: got %b exp 1", c, bus.busy); end
      n_assert++; if (bus.refill_done !== 1'b0) begin n_fail++; $display("FAIL refill_early_done c%0d: got %b exp 0", c, bus.refill_done); end
      bus.mem_rvalid = (c % 2 == 1);
      bus.mem_rdata  = (c % 2 == 1) ? A[(c-1)/2] : 32'hFFFF_FFFF;
      step();
    end
    bus.mem_rvalid = 1'b0;
    n_assert++; if (bus.refill_done !== 1'b1) begin n_fail++; $display("FAIL refill_done_c8: got %b exp 1", bus.refill_done); end
    n_assert++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL refill_idle: got %b exp 0", bus.busy); end
    step();
    n_assert++; if (bus.refill_done !== 1'b0) begin n_fail++; $display("FAIL refill_done_pulse: got %b exp 0", bus.refill_done); end
    bus.addr = 32'h48;
    #1;
    n_assert++; if (bus.read_data !== A[2]) begin n_fail++; $display("FAIL refill_read48: got %h exp %h", bus.read_data, A[2]); end
    n_assert++; if (bus.cache_hit !== 1'b1) begin n_fail++; $display("FAIL refill_hit: got %b exp 1", bus.cache_hit); end
    n_assert++; if (bus.cache_dirty !== 1'b0) begin n_fail++; $display("FAIL refill_dirty: got %b exp 0", bus.cache_dirty); end
  endtask

  task automatic test_store_hit();
    bus.addr = 32'h44;
    bus.we_cache = 1'b1;
    bus.cache_input_type = 1'b1;
    bus.set_dirty = 1'b1;
    bus.store_data = 32'hDEAD_BEEF;
    step();
    bus.we_cache = 1'b0;
    n_assert++; if (bus.read_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL store_hit_data: got %h exp deadbeef", bus.read_data); end
    n_assert++; if (bus.cache_dirty !== 1'b1) begin n_fail++; $display("FAIL store_hit_dirty: got %b exp 1", bus.cache_dirty); end
    n_assert++; if (bus.store_miss !== 1'b0) begin n_fail++; $display("FAIL store_hit_nomiss: got %b exp 0", bus.store_miss); end
  endtask

  task automatic test_writeback();
    bus.addr = 32'h444;
    #1;
    n_assert++; if (bus.cache_hit !== 1'b0) begin n_fail++; $display("FAIL conflict_hit: got %b exp 0", bus.cache_hit); end
    n_assert++; if (bus.cache_dirty !== 1'b1) begin n_fail++; $display("FAIL conflict_dirty: got %b exp 1", bus.cache_dirty); end
    bus.wb_start = 1'b1;
    step();
    bus.wb_start = 1'b0;
    bus.addr = 32'h44;
    #1;
    n_assert++; if (bus.cache_hit !== 1'b0) begin n_fail++; $display("FAIL busy_hit_forced: got %b exp 0", bus.cache_hit); end
    for (int c = 1; c <= 6; c++) begin
      int w;
      w = (c <= 3) ? 0 : c - 3;
      n_assert++; if (bus.wb_valid !== 1'b1) begin n_fail++; $display("FAIL wb_valid c%0d: got %b exp 1", c, bus.wb_valid); end
      n_assert++; if (bus.wb_addr !== 32'h40 + 32'(4 * w)) begin n_fail++; $display("FAIL wb_addr c%0d: got %h exp %h", c, bus.wb_addr, 32'h40 + 32'(4 * w)); end
      n_assert++; if (bus.wb_data !== WB[w]) begin n_fail++; $display("FAIL wb_data c%0d: got %h exp %h", c, bus.wb_data, WB[w]); end
      n_assert++; if (bus.wb_done !== 1'b0) begin n_fail++; $display("FAIL wb_early_done c%0d: got %b exp 0", c, bus.wb_done); end
      bus.mem_wready = (c >= 3);
      step();
    end
    bus.mem_wready = 1'b0;
    n_assert++; if (bus.wb_done !== 1'b1) begin n_fail++; $display("FAIL wb_done: got %b exp 1", bus.wb_done); end
    n_assert++; if ({bus.busy, bus.wb_valid} !== 2'b00) begin n_fail++; $display("FAIL wb_idle: got %b exp 00", {bus.busy, bus.wb_valid}); end
    step();
    n_assert++; if (bus.wb_done !== 1'b0) begin n_fail++; $display("FAIL wb_done_pulse: got %b exp 0", bus.wb_done); end
    bus.addr = 32'h40;
    #1;
    n_assert++; if (bus.cache_dirty !== 1'b0) begin n_fail++; $display("FAIL wb_clean: got %b exp 0", bus.cache_dirty); end
    n_assert++; if (bus.cache_hit !== 1'b1) begin n_fail++; $display("FAIL wb_still_valid: got %b exp 1", bus.cache_hit); end
  endtask

  task automatic test_both_starts();
    bus.addr = 32'h44;
    bus.wb_start = 1'b1;
    bus.refill_start = 1'b1;
    bus.we_cache = 1'b1;
    bus.cache_input_type = 1'b1;
    bus.set_dirty = 1'b1;
    bus.store_data = 32'h1234_5678;
    bus.mem_wready = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata = 32'hBAD0_BAD0;
    step();
    bus.wb_start = 1'b0;
    bus.refill_start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      n_assert++; if (bus.wb_valid !== 1'b1) begin n_fail++; $display("FAIL both_wb_valid c%0d: got %b exp 1", c, bus.wb_valid); end
      n_assert++; if (bus.wb_addr !== 32'h40 + 32'(4 * (c - 1))) begin n_fail++; $display("FAIL both_wb_addr c%0d: got %h exp %h", c, bus.wb_addr, 32'h40 + 32'(4 * (c - 1))); end
      n_assert++; if (bus.refill_done !== 1'b0) begin n_fail++; $display("FAIL both_refill_done c%0d: got %b exp 0", c, bus.refill_done); end
      if (c == 3) bus.we_cache = 1'b0;
      step();
    end
    bus.mem_wready = 1'b0;
    bus.mem_rvalid = 1'b0;
    n_assert++; if (bus.wb_done !== 1'b1) begin n_fail++; $display("FAIL both_wb_done_c5: got %b exp 1", bus.wb_done); end
    n_assert++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL both_idle: got %b exp 0", bus.busy); end
    n_assert++; if (bus.read_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL both_store_ignored: got %h exp deadbeef", bus.read_data); end
    n_assert++; if (bus.cache_dirty !== 1'b0) begin n_fail++; $display("FAIL both_dirty: got %b exp 0", bus.cache_dirty); end
    bus.addr = 32'h48;
    #1;
    n_assert++; if (bus.read_data !== A[2]) begin n_fail++; $display("FAIL both_no_refill: got %h exp %h", bus.read_data, A[2]); end
    step();
  endtask

  task automatic test_store_miss();
    bus.addr = 32'h444;
    bus.we_cache = 1'b1;
    bus.cache_input_type = 1'b1;
    bus.set_dirty = 1'b1;
    bus.store_data = 32'h5555_5555;
    #1;
    n_assert++; if (bus.store_miss !== 1'b0) begin n_fail++; $display("FAIL miss_before: got %b exp 0", bus.store_miss); end
    step();
    bus.we_cache = 1'b0;
    n_assert++; if (bus.store_miss !== 1'b1) begin n_fail++; $display("FAIL miss_pulse: got %b exp 1", bus.store_miss); end
    n_assert++; if (bus.read_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL miss_data_kept: got %h exp deadbeef", bus.read_data); end
    n_assert++; if (bus.cache_dirty !== 1'b0) begin n_fail++; $display("FAIL miss_dirty_kept: got %b exp 0", bus.cache_dirty); end
    step();
    n_assert++; if (bus.store_miss !== 1'b0) begin n_fail++; $display("FAIL miss_pulse_end: got %b exp 0", bus.store_miss); end
  endtask

  task automatic test_meta();
    bus.addr = 32'h840;
    bus.we_cache = 1'b1;
    bus.cache_input_type = 1'b0;
    bus.set_valid = 1'b1;
    bus.set_dirty = 1'b1;
    step();
    bus.we_cache = 1'b0;
    n_assert++; if (bus.cache_hit !== 1'b1) begin n_fail++; $display("FAIL meta_hit: got %b exp 1", bus.cache_hit); end
    n_assert++; if (bus.cache_dirty !== 1'b1) begin n_fail++; $display("FAIL meta_dirty: got %b exp 1", bus.cache_dirty); end
    n_assert++; if (bus.read_data !== A[0]) begin n_fail++; $display("FAIL meta_data_kept: got %h exp %h", bus.read_data, A[0]); end
    bus.addr = 32'h40;
    #1;
    n_assert++; if (bus.cache_hit !== 1'b0) begin n_fail++; $display("FAIL meta_old_tag: got %b exp 0", bus.cache_hit); end
  endtask

  task automatic test_reset_mid_burst();
    bus.addr = 32'h40;
    bus.refill_start = 1'b1;
    step();
    bus.refill_start = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata = A[0];
    step();
    bus.mem_rdata = A[1];
    step();
    bus.mem_rvalid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_assert++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b exp 0", bus.busy); end
    n_assert++; if (bus.cache_hit !== 1'b0) begin n_fail++; $display("FAIL rstmid_hit: got %b exp 0", bus.cache_hit); end
    n_assert++; if (bus.refill_done !== 1'b0) begin n_fail++; $display("FAIL rstmid_done: got %b exp 0", bus.refill_done); end
    step();
    rst_n = 1'b1;
    bus.mem_rvalid = 1'b1;
    step();
    step();
    bus.mem_rvalid = 1'b0;
    n_assert++; if ({bus.busy, bus.refill_done, bus.cache_hit} !== 3'b000) begin
      n_fail++; $display("FAIL rstmid_after: got %b exp 000", {bus.busy, bus.refill_done, bus.cache_hit}); end
  endtask

  initial begin
    bus.addr = '0; bus.we_cache = 1'b0; bus.cache_input_type = 1'b0;
    bus.set_valid = 1'b0; bus.set_dirty = 1'b0; bus.store_data = '0;
    bus.wb_start = 1'b0; bus.refill_start = 1'b0; bus.mem_wready = 1'b0;
    bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    test_reset();
    test_refill();
    test_store_hit();
    test_writeback();
    test_both_starts();
    test_store_miss();
    test_meta();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
